// File: rtl/fetch_stage.sv
// MIPS instruction fetch stage: owns the PC, drives instruction memory and holds the IF/ID register.
// Next-PC selection honours decode-stage redirects (jr > j > taken branch) with a one-bubble penalty.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_d,
    input  logic        pc_src_d,
    input  logic [1:0]  jump_d,
    input  logic [31:0] rs_data_d,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d_n;
    logic [31:0] pc_plus4_q, pc_plus4_d_n;
    logic        valid_q, valid_d_n;

    logic        is_jr, is_j, redirect;
    logic [31:0] pc_inc, jr_target, j_target, br_target, target;

    assign is_jr    = (jump_d == 2'b10);
    assign is_j     = (jump_d == 2'b01);
    // Stale decode outputs during a bubble must not redirect again.
    assign redirect = valid_q & (pc_src_d | is_j | is_jr);

    assign pc_inc    = pc_q + 32'd4;
    assign jr_target = {rs_data_d[31:2], 2'b00};
    assign j_target  = {pc_plus4_q[31:28], instr_q[25:0], 2'b00};
    assign br_target = pc_plus4_q + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

    always_comb begin
        target = br_target;
        if (is_jr) begin
            target = jr_target;
        end else if (is_j) begin
            target = j_target;
        end
    end

    always_comb begin
        pc_d         = pc_q;
        instr_d_n    = instr_q;
        pc_plus4_d_n = pc_plus4_q;
        valid_d_n    = valid_q;
        if (!stall_d) begin
            if (redirect) begin
                pc_d         = target;
                instr_d_n    = NOP_INSTR;
                pc_plus4_d_n = 32'd0;
                valid_d_n    = 1'b0;
            end else if (imem_ready) begin
                pc_d         = pc_inc;
                instr_d_n    = imem_rdata;
                pc_plus4_d_n = pc_inc;
                valid_d_n    = 1'b1;
            end else begin
                instr_d_n    = NOP_INSTR;
                pc_plus4_d_n = 32'd0;
                valid_d_n    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= 32'd0;
            valid_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d_n;
            pc_plus4_q <= pc_plus4_d_n;
            valid_q    <= valid_d_n;
        end
    end

    assign imem_addr  = pc_q;
    assign pc_f       = pc_q;
    assign instr_d    = instr_q;
    assign pc_plus4_d = pc_plus4_q;
    assign valid_d    = valid_q;

endmodule
